// File: rtl/mul_sequencer_if.sv
// Handshake and product-write bundle between the decode/control unit and the
// shift-add multiply sequencer.
interface mul_sequencer_if #(
    parameter int unsigned WIDTH = 24
);
    logic                 Start;
    logic                 Signed;
    logic [WIDTH-1:0]     OperandA;
    logic [WIDTH-1:0]     OperandB;
    logic                 Busy;
    logic                 Stall;
    logic                 Done;
    logic                 Mulwrite;
    logic [2*WIDTH-1:0]   WriteMul;

    modport master (
        output Start, Signed, OperandA, OperandB,
        input  Busy, Stall, Done, Mulwrite, WriteMul
    );

    modport slave (
        input  Start, Signed, OperandA, OperandB,
        output Busy, Stall, Done, Mulwrite, WriteMul
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply sequencer: WIDTH add/shift steps on magnitudes,
// a sign-fix step, then a one-cycle write into the product register file.
module mul_sequencer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic           Clock,
    input  logic           ResetN,
    mul_sequencer_if.slave mul_if
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, WRITE} state_t;

    state_t               state;
    logic                 busy;
    logic                 done;
    logic                 mulwrite;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic                 neg;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       add_sum;

    // -2^(WIDTH-1) negates to itself, which is already the correct unsigned magnitude.
    always_comb begin
        mag_a   = (mul_if.Signed && mul_if.OperandA[WIDTH-1]) ? -mul_if.OperandA : mul_if.OperandA;
        mag_b   = (mul_if.Signed && mul_if.OperandB[WIDTH-1]) ? -mul_if.OperandB : mul_if.OperandB;
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    // Lower half of acc holds the multiplier and is consumed as the partial product grows in.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mulwrite <= 1'b0;
            product  <= '0;
            mcand    <= '0;
            acc      <= '0;
            count    <= '0;
            neg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_if.Start) begin
                        mcand <= mag_a;
                        acc   <= {{WIDTH{1'b0}}, mag_b};
                        neg   <= mul_if.Signed & (mul_if.OperandA[WIDTH-1] ^ mul_if.OperandB[WIDTH-1]);
                        count <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= {add_sum, acc[WIDTH-1:1]};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    product  <= neg ? -acc : acc;
                    mulwrite <= 1'b1;
                    done     <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    mulwrite <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mul_if.Busy     = busy;
    assign mul_if.Done     = done;
    assign mul_if.Mulwrite = mulwrite;
    assign mul_if.WriteMul = product;
    assign mul_if.Stall    = ((state == IDLE) && mul_if.Start) || (state == RUN) || (state == FIX);
endmodule
